alu_issue_sequencer: RTL and testbench
======================================

# alu_issue_sequencer

Command front-end and result back-end wrapped around the 16-bit ALU. Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, drives the ALU operand and opcode inputs one command at a time, waits the opcode-dependent settle latency, and captures `rezultat` into a registered, tagged result port with its own valid/ready handshake. It is the only block that drives the ALU's `A`, `B` and `op` inputs.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `TAG_W`, 4: width of the opaque command tag
- `COMB_LAT`, 1: clock edges from issue to capture for combinational opcodes
- `SHIFT_LAT`, 2: clock edges from issue to capture for shift opcodes 0110/0111
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_b`  in  1  synchronous, active-high reset (asserted = 1, sampled on `clk` rising edge)
- `in_valid`  in  1  command present
- `in_ready`  out  1  FIFO can accept; equals !full and is independent of same-cycle pop
- `in_a`, `in_b`  in  16 each  operands
- `in_op`  in  4  ALU opcode
- `in_tag`  in  TAG_W  returned unchanged with the result
- `alu_a`, `alu_b`  out  16 each  registered; to ALU `A`, `B`
- `alu_op`  out  4  registered; to ALU `op`
- `alu_rezultat`  in  32  from ALU `rezultat`
- `out_valid`  in/out: out  1  result held
- `out_ready`  in  1  consumer accepts
- `out_result`  out  32  captured result
- `out_tag`  out  TAG_W  tag of the result
- `out_err`  out  1  opcode was 1010–1111 (unsupported)
- `out_dz`  out  1  opcode 1001 with `in_b` = 0
- `busy`  out  1  state ≠ IDLE or FIFO non-empty
- `count`  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: `in_valid && in_ready` writes {a,b,op,tag} at write pointer; pointers wrap modulo DEPTH. Push while full is impossible (`in_ready`=0).
- FSM states IDLE, WAIT, HOLD.
- IDLE: if FIFO non-empty, pop head; load `alu_a/alu_b/alu_op`, tag, flags; if op valid load wait counter with latency (SHIFT_LAT for 0110/0111, else COMB_LAT) → WAIT; if op invalid → HOLD directly with `out_result`=0, `out_err`=1, `alu_*` unchanged.
- WAIT: decrement counter each edge; on the edge where it reaches zero, capture `alu_rezultat` into `out_result`, set `out_valid`=1 → HOLD.
- HOLD: `out_*` stable while `out_valid && !out_ready`. On `out_valid && out_ready`: if FIFO non-empty pop next in the same edge (as IDLE) and go WAIT/HOLD, else clear `out_valid` → IDLE.
- `alu_a/alu_b/alu_op` stay stable from issue until the next issue (ALU shift registers see a constant input).
- `out_dz` computed at issue; result still the ALU's value (no substitution).
- Simultaneous push and pop: both occur; `count` unchanged.

## Timing
- Reset (rst_b=1 at edge): state IDLE, FIFO emptied, `count`=0, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_tag`=0, `out_err`=0, `out_dz`=0, `alu_a`=`alu_b`=0, `alu_op`=0000, `busy`=0. Reset mid-WAIT/HOLD discards in-flight and queued commands; no result emitted.
- Empty pipeline latency, push edge t: pop/issue edge t+1, capture edge t+1+L, `out_valid` visible after t+1+L (L=COMB_LAT or SHIFT_LAT; invalid op: `out_valid` after t+1).
- Back-to-back throughput with `out_ready`=1: one result per L+1 edges.
- Capacity with `out_ready`=0: DEPTH queued + 1 in flight.

## Test plan
- Divide: a=9, b=3, op=1001, tag=5 -> `out_result`=0x00000003, `out_tag`=5, `out_dz`=0, `out_valid` 2 edges after push.
- Add then xor back-to-back: (5,7,0100) then (0x00F0,0x0FF0,0011), `out_ready`=1 -> 0x0000000C then 0x00000F00, in order, 2 edges apart.
- Right shift: a=0x0010, op=0110 -> 0x00000008, `out_valid` 3 edges after push.
- Backpressure: `out_ready`=0, push 6 commands -> exactly 5 accepted, `in_ready`=0, `count`=4; release -> 5 results in push order, tags intact.
- Errors: op=1111 -> `out_result`=0, `out_err`=1, `alu_op` unchanged; a=7, b=0, op=1001 -> `out_dz`=1.
- Reset during WAIT with 2 queued -> next edge `out_valid`=0, `count`=0, `in_ready`=1; no stale result afterwards.

Source files
------------

// File: rtl/alu_issue_if.sv
// Command and result handshake bundle between a command producer/result consumer
// and alu_issue_sequencer.
interface alu_issue_if #(
  parameter int unsigned TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [3:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             out_dz;

  // Producer of commands / consumer of results.
  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_err, out_dz
  );

  // The sequencer itself.
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_err, out_dz
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Queues ALU commands, issues them one at a time to the ALU operand/opcode inputs,
// waits the opcode latency and returns the tagged result over a valid/ready port.
module alu_issue_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned COMB_LAT  = 1,
  parameter int unsigned SHIFT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_b,
  alu_issue_if.slave                 bus,
  output logic [15:0]                alu_a,
  output logic [15:0]                alu_b,
  output logic [3:0]                 alu_op,
  input  logic [31:0]                alu_rezultat,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned MAX_LAT = (SHIFT_LAT > COMB_LAT) ? SHIFT_LAT : COMB_LAT;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  typedef struct packed {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [3:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [15:0]      alu_a_q, alu_a_d;
  logic [15:0]      alu_b_q, alu_b_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic             out_dz_q, out_dz_d;

  cmd_t in_cmd;
  cmd_t head;
  logic in_ready_c;
  logic push;
  logic issue;
  logic empty;

  assign in_ready_c = (count_q != CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push       = bus.in_valid && in_ready_c;
  assign head       = mem_q[rd_ptr_q];

  // Next-state: FIFO bookkeeping, issue decision and result capture.
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    lat_cnt_d    = lat_cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    out_dz_d     = out_dz_q;
    issue        = 1'b0;

    in_cmd.a   = bus.in_a;
    in_cmd.b   = bus.in_b;
    in_cmd.op  = bus.in_op;
    in_cmd.tag = bus.in_tag;

    case (state_q)
      S_IDLE: begin
        if (!empty) issue = 1'b1;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_W'(1)) begin
          out_result_d = alu_rezultat;
          out_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) issue = 1'b1;
          else        state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Unsupported opcodes never reach the ALU; they complete immediately with err set.
    if (issue) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_tag_d = head.tag;
      out_dz_d  = (head.op == 4'b1001) && (head.b == 16'h0000);
      if (head.op >= 4'b1010) begin
        out_err_d    = 1'b1;
        out_result_d = 32'h0000_0000;
        out_valid_d  = 1'b1;
        state_d      = S_HOLD;
      end else begin
        out_err_d = 1'b0;
        alu_a_d   = head.a;
        alu_b_d   = head.b;
        alu_op_d  = head.op;
        lat_cnt_d = (head.op[3:1] == 3'b011) ? LAT_W'(SHIFT_LAT) : LAT_W'(COMB_LAT);
        state_d   = S_WAIT;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = in_cmd;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(issue);
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lat_cnt_q    <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      out_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lat_cnt_q    <= lat_cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      out_dz_q     <= out_dz_d;
    end
    mem_q <= mem_d;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_dz     = out_dz_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_op         = alu_op_q;
  assign count          = count_q;
  assign busy           = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small ALU model whose shifts
// take one registered stage, so early capture of a shift result is visible.
module tb_alu_issue_sequencer;

  logic        clk;
  logic        rst_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_rezultat;
  logic        busy;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue_if #(.TAG_W(4)) bus ();

  alu_issue_sequencer #(
    .DEPTH(4), .TAG_W(4), .COMB_LAT(1), .SHIFT_LAT(2)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_rezultat (alu_rezultat),
    .busy         (busy),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: shift results appear one edge after the operand is presented.
  logic [15:0] sh_q;
  always @(posedge clk) sh_q <= (alu_op == 4'b0111) ? (alu_a << 1) : (alu_a >> 1);

  always_comb begin
    case (alu_op)
      4'b0011:          alu_rezultat = {16'h0, alu_a ^ alu_b};
      4'b0100:          alu_rezultat = {16'h0, alu_a} + {16'h0, alu_b};
      4'b1001:          alu_rezultat = (alu_b == 16'h0) ? 32'hFFFF_FFFF : {16'h0, alu_a / alu_b};
      4'b0110, 4'b0111: alu_rezultat = {16'h0, sh_q};
      default:          alu_rezultat = {16'h0, alu_a & alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  // Advance at least one edge, then until out_valid is seen (bounded).
  task automatic wait_out(output int cyc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.out_valid && n < 30);
    if (!bus.out_valid) check("wait_out_timeout", 32'd0, 32'd1);
    cyc = n;
  endtask

  int       cyc;
  int       accepted;
  logic     seen;

  initial begin
    rst_b         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_b = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(count),         32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_alu_op",    32'(alu_op),        32'd0);
    check("rst_result",    bus.out_result,     32'd0);
    check("rst_busy",      32'(busy),          32'd0);

    // Divide 9/3, valid two edges after push, held under backpressure.
    drive(16'd9, 16'd3, 4'b1001, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    check("div_valid_e0", 32'(bus.out_valid), 32'd0);
    check("div_count_e0", 32'(count), 32'd1);
    tick();
    check("div_valid_e1", 32'(bus.out_valid), 32'd0);
    check("div_alu_op",   32'(alu_op), 32'd9);
    check("div_busy",     32'(busy), 32'd1);
    tick();
    check("div_valid_e2", 32'(bus.out_valid), 32'd1);
    check("div_result",   bus.out_result, 32'h0000_0003);
    check("div_tag",      32'(bus.out_tag), 32'd5);
    check("div_dz",       32'(bus.out_dz), 32'd0);
    tick();
    check("div_held",     32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("div_consumed", 32'(bus.out_valid), 32'd0);
    check("div_idle",     32'(busy), 32'd0);

    // Add then xor back to back, two edges apart.
    drive(16'd5, 16'd7, 4'b0100, 4'd1);
    tick();
    drive(16'h00F0, 16'h0FF0, 4'b0011, 4'd2);
    tick();
    bus.in_valid = 1'b0;
    wait_out(cyc);
    check("add_result", bus.out_result, 32'h0000_000C);
    check("add_tag",    32'(bus.out_tag), 32'd1);
    wait_out(cyc);
    check("xor_result", bus.out_result, 32'h0000_0F00);
    check("xor_tag",    32'(bus.out_tag), 32'd2);
    check("xor_spacing", 32'(cyc), 32'd2);
    tick();

    // Right shift: three edges from push to valid.
    drive(16'h0010, 16'h0000, 4'b0110, 4'd3);
    tick();
    bus.in_valid = 1'b0;
    wait_out(cyc);
    check("shr_result",  bus.out_result, 32'h0000_0008);
    check("shr_latency", 32'(cyc), 32'd3);
    tick();

    // Backpressure: 4 queued + 1 in flight, sixth push refused.
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      drive(16'(i + 1), 16'd2, 4'b0100, 4'(i + 1));
      if (bus.in_ready) accepted++;
      tick();
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(accepted), 32'd5);
    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp_count",    32'(count), 32'd4);
    check("bp_r0_valid", 32'(bus.out_valid), 32'd1);
    check("bp_r0",       bus.out_result, 32'd3);
    check("bp_t0",       32'(bus.out_tag), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      wait_out(cyc);
      check($sformatf("bp_r%0d", i), bus.out_result, 32'(i + 3));
      check($sformatf("bp_t%0d", i), 32'(bus.out_tag), 32'(i + 1));
    end
    tick();
    tick();
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'd0);
    check("bp_idle",    32'(busy), 32'd0);

    // Unsupported opcode completes one edge after issue, ALU inputs untouched.
    bus.out_ready = 1'b0;
    drive(16'h1234, 16'd1, 4'b1111, 4'd7);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("err_valid",  32'(bus.out_valid), 32'd1);
    check("err_flag",   32'(bus.out_err), 32'd1);
    check("err_result", bus.out_result, 32'd0);
    check("err_alu_op", 32'(alu_op), 32'(4'b0100));
    check("err_tag",    32'(bus.out_tag), 32'd7);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Divide by zero: flag set, ALU value passed through.
    drive(16'd7, 16'd0, 4'b1001, 4'd2);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("dz_valid",  32'(bus.out_valid), 32'd1);
    check("dz_flag",   32'(bus.out_dz), 32'd1);
    check("dz_err",    32'(bus.out_err), 32'd0);
    check("dz_result", bus.out_result, 32'hFFFF_FFFF);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset while one shift is in flight and two are queued.
    drive(16'h0100, 16'd0, 4'b0110, 4'd1);
    tick();
    drive(16'h0200, 16'd0, 4'b0110, 4'd2);
    tick();
    drive(16'h0400, 16'd0, 4'b0110, 4'd3);
    tick();
    bus.in_valid = 1'b0;
    check("mid_count", 32'(count), 32'd2);
    check("mid_valid", 32'(bus.out_valid), 32'd0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("rr_valid",    32'(bus.out_valid), 32'd0);
    check("rr_count",    32'(count), 32'd0);
    check("rr_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("rr_no_stale", 32'(seen), 32'd0);
    check("rr_idle",     32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
